regfile_load_unit: RTL and testbench

- Parametrised register-file and writeback stage for the flow CPU datapath.
- Register 0 is the program counter (PC); registers 1..NREGS-1 are general purpose.
- Each register carries overflow and error flags, plus combinational zero and sign flag vectors.
- ALU results are written back in a single cycle; memory loads go through a variable-latency valid handshake with a timeout, and the unit stalls the PC while a load is outstanding.

---
 rtl/regfile_load_unit.sv | 143 ++++++++++++++
 tb/tb_regfile_load_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_load_unit.sv
// ---------------------------------------------------------------------------
// regfile_load_unit
//
// Register file and writeback stage for the flow CPU datapath. Register 0 is
// the program counter; registers 1..NREGS-1 are general purpose. Each
// register carries overflow and error flags. Zero and sign flags are derived
// combinationally from the committed register values.
//
// ALU results are written back in one cycle. Memory loads use a two-state
// controller (IDLE/WAIT) that waits for ld_valid with a timeout. The PC is
// frozen while a load is outstanding.
//
// Ports
//   clock, resetn                    clock, synchronous active-low reset
//   pc_inc                           add 1 to the PC this cycle
//   wr_en, wr_src, wr_sel            writeback request, source (0 ALU, 1 load),
//                                    destination register
//   alu_result, alu_ofl, alu_err     ALU data and flags
//   ld_valid, ld_data                memory load handshake and data
//   rd_{a,b,c}_sel / rd_{a,b,c}      combinational read ports (no bypass)
//   pc, busy                         register 0 value, load outstanding
//   registers                        flat view, register i at [i*WIDTH +: WIDTH]
//   zeroflag, signflag               per-register zero / MSB flags
//   overflow, errorbit               per-register stored flags
// ---------------------------------------------------------------------------
module regfile_load_unit #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 16,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   pc_inc,
  input  logic                   wr_en,
  input  logic                   wr_src,
  input  logic [SELW-1:0]        wr_sel,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_ofl,
  input  logic                   alu_err,
  input  logic                   ld_valid,
  input  logic [WIDTH-1:0]       ld_data,
  input  logic [SELW-1:0]        rd_a_sel,
  input  logic [SELW-1:0]        rd_b_sel,
  input  logic [SELW-1:0]        rd_c_sel,
  output logic [WIDTH-1:0]       rd_a,
  output logic [WIDTH-1:0]       rd_b,
  output logic [WIDTH-1:0]       rd_c,
  output logic [WIDTH-1:0]       pc,
  output logic                   busy,
  output logic [NREGS*WIDTH-1:0] registers,
  output logic [NREGS-1:0]       zeroflag,
  output logic [NREGS-1:0]       signflag,
  output logic [NREGS-1:0]       overflow,
  output logic [NREGS-1:0]       errorbit
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [SELW-1:0]   dest;
  logic [CW-1:0]     cnt;
  logic              wr_ok;

  assign wr_ok = (32'(wr_sel) < NREGS);

  // Out-of-range selects read as zero rather than aliasing a real register.
  function automatic logic [WIDTH-1:0] read_reg(input logic [SELW-1:0] sel);
    if (32'(sel) < NREGS) return regs[sel];
    return '0;
  endfunction

  assign rd_a = read_reg(rd_a_sel);
  assign rd_b = read_reg(rd_b_sel);
  assign rd_c = read_reg(rd_c_sel);
  assign pc   = regs[0];
  assign busy = (state == S_WAIT);

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign registers[i*WIDTH +: WIDTH] = regs[i];
    assign zeroflag[i]                 = (regs[i] == '0);
    assign signflag[i]                 = regs[i][WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the register array is architecturally visible state that must
      // read as zero after reset, so every entry is cleared here rather than
      // left uninitialised like a plain RAM.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      overflow <= '0;
      errorbit <= '0;
      state    <= S_IDLE;
      dest     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // NOTE: later non-blocking assignments to regs[0] in this block
          // override this default increment; that ordering is intentional.
          regs[0] <= regs[0] + WIDTH'(pc_inc);
          if (wr_en && wr_ok) begin
            if (!wr_src) begin
              // A write to register 0 still honours pc_inc on the new value.
              regs[wr_sel]     <= alu_result +
                                  ((wr_sel == '0) ? WIDTH'(pc_inc) : '0);
              overflow[wr_sel] <= alu_ofl;
              errorbit[wr_sel] <= alu_err;
            end else begin
              // Accepting a load freezes the PC in this same cycle.
              regs[0] <= regs[0];
              dest    <= wr_sel;
              cnt     <= '0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (ld_valid) begin
            // Data arriving on the timeout cycle still wins.
            regs[dest]     <= ld_data;
            overflow[dest] <= 1'b0;
            errorbit[dest] <= 1'b0;
            state          <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            errorbit[dest] <= 1'b1;
            state          <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_load_unit.sv
// ---------------------------------------------------------------------------
// tb_regfile_load_unit
//
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the register file held in plain arrays.
// ---------------------------------------------------------------------------
module tb_regfile_load_unit;

  localparam int WIDTH   = 16;
  localparam int NREGS   = 16;
  localparam int SELW    = 4;
  localparam int TIMEOUT = 15;

  logic                   clock = 1'b0;
  logic                   resetn;
  logic                   pc_inc;
  logic                   wr_en;
  logic                   wr_src;
  logic [SELW-1:0]        wr_sel;
  logic [WIDTH-1:0]       alu_result;
  logic                   alu_ofl;
  logic                   alu_err;
  logic                   ld_valid;
  logic [WIDTH-1:0]       ld_data;
  logic [SELW-1:0]        rd_a_sel, rd_b_sel, rd_c_sel;
  logic [WIDTH-1:0]       rd_a, rd_b, rd_c;
  logic [WIDTH-1:0]       pc;
  logic                   busy;
  logic [NREGS*WIDTH-1:0] registers;
  logic [NREGS-1:0]       zeroflag, signflag, overflow, errorbit;

  regfile_load_unit #(
    .WIDTH(WIDTH), .NREGS(NREGS), .SELW(SELW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .resetn(resetn), .pc_inc(pc_inc),
    .wr_en(wr_en), .wr_src(wr_src), .wr_sel(wr_sel),
    .alu_result(alu_result), .alu_ofl(alu_ofl), .alu_err(alu_err),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_c_sel(rd_c_sel),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .pc(pc), .busy(busy), .registers(registers),
    .zeroflag(zeroflag), .signflag(signflag),
    .overflow(overflow), .errorbit(errorbit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: register contents, flags and the outstanding load.
  logic [WIDTH-1:0] m_reg [NREGS];
  logic [NREGS-1:0] m_ofl, m_err;
  bit               m_busy;
  int               m_dest;
  int               m_waited;   // WAIT cycles elapsed, counting this one

  task automatic model_step();
    if (!resetn) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_ofl = '0; m_err = '0; m_busy = 0; m_waited = 0;
    end else if (!m_busy) begin
      if (wr_en && int'(wr_sel) < NREGS && wr_src) begin
        m_busy = 1; m_dest = int'(wr_sel); m_waited = 0;  // PC frozen
      end else begin
        m_reg[0] = m_reg[0] + WIDTH'(pc_inc);
        if (wr_en && int'(wr_sel) < NREGS) begin
          m_reg[wr_sel] = (wr_sel == 0) ? alu_result + WIDTH'(pc_inc) : alu_result;
          m_ofl[wr_sel] = alu_ofl;
          m_err[wr_sel] = alu_err;
        end
      end
    end else begin
      m_waited++;
      if (ld_valid) begin
        m_reg[m_dest] = ld_data;
        m_ofl[m_dest] = 1'b0;
        m_err[m_dest] = 1'b0;
        m_busy = 0;
      end else if (m_waited == TIMEOUT) begin
        m_err[m_dest] = 1'b1;
        m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NREGS*WIDTH-1:0] flat;
    logic [NREGS-1:0]       zf, sf;
    for (int i = 0; i < NREGS; i++) begin
      flat[i*WIDTH +: WIDTH] = m_reg[i];
      zf[i] = (m_reg[i] == 0);
      sf[i] = m_reg[i][WIDTH-1];
    end
    check("pc",        pc,        m_reg[0]);
    check("busy",      busy,      m_busy);
    check("registers", registers, flat);
    check("zeroflag",  zeroflag,  zf);
    check("signflag",  signflag,  sf);
    check("overflow",  overflow,  m_ofl);
    check("errorbit",  errorbit,  m_err);
    check("rd_a",      rd_a,      m_reg[rd_a_sel]);
    check("rd_b",      rd_b,      m_reg[rd_b_sel]);
    check("rd_c",      rd_c,      m_reg[rd_c_sel]);
  endtask

  // One clock: model and DUT both take the current inputs at the edge,
  // outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    rd_a_sel = SELW'($urandom);
    rd_b_sel = SELW'($urandom);
    rd_c_sel = SELW'($urandom);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; pc_inc = 1'b0; wr_en = 1'b0; wr_src = 1'b0; wr_sel = '0;
    alu_result = '0; alu_ofl = 1'b0; alu_err = 1'b0;
    ld_valid = 1'b0; ld_data = '0;
  endtask

  task automatic alu_write(input int sel, input logic [WIDTH-1:0] val,
                           input logic ofl, input logic err);
    wr_en = 1'b1; wr_src = 1'b0; wr_sel = SELW'(sel);
    alu_result = val; alu_ofl = ofl; alu_err = err;
    tick();
    wr_en = 1'b0; alu_ofl = 1'b0; alu_err = 1'b0;
  endtask

  task automatic load_request(input int sel);
    wr_en = 1'b1; wr_src = 1'b1; wr_sel = SELW'(sel);
    tick();
    wr_en = 1'b0; wr_src = 1'b0;
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = 'x;
    m_ofl = 'x; m_err = 'x; m_busy = 0; m_dest = 0; m_waited = 0;
    rd_a_sel = '0; rd_b_sel = '0; rd_c_sel = '0;
    idle_inputs();

    // Reset, then count the PC up.
    resetn = 1'b0; pc_inc = 1'b1;
    tick(); tick();
    check("reset_zeroflag", zeroflag, 16'hFFFF);
    resetn = 1'b1;
    repeat (5) tick();
    check("pc_after_5", pc, 16'd5);
    check("zeroflag_pc5", zeroflag, 16'hFFFE);
    check("upper_regs_zero", registers[255:16], '0);

    // ALU write with overflow and negative result.
    alu_write(3, 16'h8000, 1'b1, 1'b0);
    rd_a_sel = 4'd3; #1;
    check("rd_a_reg3", rd_a, 16'h8000);
    check("sign3_ofl3", {signflag[3], overflow[3], zeroflag[3]}, 3'b110);

    // Load to reg 5, data on the 4th WAIT cycle; reg 6 write attempt in WAIT.
    load_request(5);
    wr_en = 1'b1; wr_src = 1'b0; wr_sel = 4'd6; alu_result = 16'hBEEF;
    repeat (3) tick();
    wr_en = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h1234;
    tick();
    ld_valid = 1'b0;
    check("reg5_loaded", registers[5*16 +: 16], 16'h1234);
    check("reg6_untouched", registers[6*16 +: 16], 16'h0000);

    // Timeout on reg 7, then a load with immediate valid clears the error.
    alu_write(7, 16'h00AA, 1'b0, 1'b0);
    load_request(7);
    repeat (TIMEOUT - 1) tick();
    check("busy_before_abort", busy, 1'b1);
    tick();
    check("abort_err7", {busy, errorbit[7]}, 2'b01);
    check("abort_reg7", registers[7*16 +: 16], 16'h00AA);
    load_request(7);
    ld_valid = 1'b1; ld_data = 16'h0777;
    tick();
    ld_valid = 1'b0;
    check("reload_err7", errorbit[7], 1'b0);

    // PC wrap and PC write.
    alu_write(0, 16'hFFFE, 1'b0, 1'b0);
    check("pc_ffff", pc, 16'hFFFF);
    tick();
    check("pc_wrap", pc, 16'h0000);
    alu_write(0, 16'h0100, 1'b0, 1'b0);
    check("pc_write", pc, 16'h0101);

    // Load into the PC: no increment on completion.
    load_request(0);
    ld_valid = 1'b1; ld_data = 16'h4000;
    tick();
    ld_valid = 1'b0;
    check("pc_load", pc, 16'h4000);

    // Reset in the middle of a load; later valid must be ignored.
    load_request(2);
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; ld_valid = 1'b1; ld_data = 16'h5555;
    tick();
    ld_valid = 1'b0;
    check("midreset_reg2", {busy, registers[2*16 +: 16]}, 17'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      resetn     = ($urandom_range(0, 99) != 0);
      pc_inc     = 1'($urandom);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_src     = 1'($urandom);
      wr_sel     = SELW'($urandom);
      alu_result = ($urandom_range(0, 7) == 0) ? 16'hFFFF : WIDTH'($urandom);
      alu_ofl    = 1'($urandom);
      alu_err    = 1'($urandom);
      ld_valid   = ($urandom_range(0, 5) == 0);
      ld_data    = ($urandom_range(0, 7) == 0) ? 16'h0000 : WIDTH'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
